// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decode-stage fields in, registered EX-stage copies out.
// Handshake: there is no valid/ready pair here; the EX side sees valid_o, and
// the decode side must honour stall_o (combinational) before the next edge.
interface id_ex_stage_if #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
);
   logic                  reg_dst_i, branch_eq_i, branch_ne_i, mem_read_i, mem_to_reg_i;
   logic                  mem_write_i, alu_src_i, reg_write_i, jump_i, jr_i;
   logic [2:0]            alu_op_i;
   logic [4:0]            rs_i, rt_i, rd_i;
   logic [DATA_WIDTH-1:0] read_data_1_i, read_data_2_i, imm_ext_i, pc_plus4_i;
   logic                  flush_i, hold_i;

   logic                  reg_dst_o, branch_eq_o, branch_ne_o, mem_read_o, mem_to_reg_o;
   logic                  mem_write_o, alu_src_o, reg_write_o, jump_o, jr_o;
   logic [2:0]            alu_op_o;
   logic [4:0]            rs_o, rt_o, rd_o;
   logic [DATA_WIDTH-1:0] read_data_1_o, read_data_2_o, imm_ext_o, pc_plus4_o;
   logic                  valid_o, stall_o;
   logic [CNT_WIDTH-1:0]  bubble_count_o;

   // Decode-side driver
   modport master (
      output reg_dst_i, branch_eq_i, branch_ne_i, mem_read_i, mem_to_reg_i,
             mem_write_i, alu_src_i, reg_write_i, jump_i, jr_i, alu_op_i,
             rs_i, rt_i, rd_i, read_data_1_i, read_data_2_i, imm_ext_i, pc_plus4_i,
             flush_i, hold_i,
      input  reg_dst_o, branch_eq_o, branch_ne_o, mem_read_o, mem_to_reg_o,
             mem_write_o, alu_src_o, reg_write_o, jump_o, jr_o, alu_op_o,
             rs_o, rt_o, rd_o, read_data_1_o, read_data_2_o, imm_ext_o, pc_plus4_o,
             valid_o, stall_o, bubble_count_o
   );

   // Pipeline register side
   modport slave (
      input  reg_dst_i, branch_eq_i, branch_ne_i, mem_read_i, mem_to_reg_i,
             mem_write_i, alu_src_i, reg_write_i, jump_i, jr_i, alu_op_i,
             rs_i, rt_i, rd_i, read_data_1_i, read_data_2_i, imm_ext_i, pc_plus4_i,
             flush_i, hold_i,
      output reg_dst_o, branch_eq_o, branch_ne_o, mem_read_o, mem_to_reg_o,
             mem_write_o, alu_src_o, reg_write_o, jump_o, jr_o, alu_op_o,
             rs_o, rt_o, rd_o, read_data_1_o, read_data_2_o, imm_ext_o, pc_plus4_o,
             valid_o, stall_o, bubble_count_o
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush and hold.
// Optional feature macro: ID_EX_HAZARD_DETECT_EN (load-use detection, stall_o
// and the saturating bubble counter). Undefined: no hazard, stall_o = 0,
// bubble_count_o = 0.
module id_ex_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input logic clk,
   input logic reset,
   id_ex_stage_if.slave bus
);

   typedef struct packed {
      logic                  valid;
      logic                  reg_dst;
      logic                  branch_eq;
      logic                  branch_ne;
      logic                  mem_read;
      logic                  mem_to_reg;
      logic                  mem_write;
      logic                  alu_src;
      logic                  reg_write;
      logic                  jump;
      logic                  jr;
      logic [2:0]            alu_op;
      logic [4:0]            rs;
      logic [4:0]            rt;
      logic [4:0]            rd;
      logic [DATA_WIDTH-1:0] rd1;
      logic [DATA_WIDTH-1:0] rd2;
      logic [DATA_WIDTH-1:0] imm;
      logic [DATA_WIDTH-1:0] pc4;
   } stage_t;

   stage_t stage_d, stage_q;
   stage_t incoming, bubble;
   logic   hazard;

   // Assemble the decode-stage instruction and its bubble variant
   always_comb begin
      incoming            = '0;
      incoming.valid      = 1'b1;
      incoming.reg_dst    = bus.reg_dst_i;
      incoming.branch_eq  = bus.branch_eq_i;
      incoming.branch_ne  = bus.branch_ne_i;
      incoming.mem_read   = bus.mem_read_i;
      incoming.mem_to_reg = bus.mem_to_reg_i;
      incoming.mem_write  = bus.mem_write_i;
      incoming.alu_src    = bus.alu_src_i;
      incoming.reg_write  = bus.reg_write_i;
      incoming.jump       = bus.jump_i;
      incoming.jr         = bus.jr_i;
      incoming.alu_op     = bus.alu_op_i;
      incoming.rs         = bus.rs_i;
      incoming.rt         = bus.rt_i;
      incoming.rd         = bus.rd_i;
      incoming.rd1        = bus.read_data_1_i;
      incoming.rd2        = bus.read_data_2_i;
      incoming.imm        = bus.imm_ext_i;
      incoming.pc4        = bus.pc_plus4_i;
      // A bubble keeps the data/specifier fields but has no side effects
      bubble              = incoming;
      bubble.valid        = 1'b0;
      bubble.reg_dst      = 1'b0;
      bubble.branch_eq    = 1'b0;
      bubble.branch_ne    = 1'b0;
      bubble.mem_read     = 1'b0;
      bubble.mem_to_reg   = 1'b0;
      bubble.mem_write    = 1'b0;
      bubble.alu_src      = 1'b0;
      bubble.reg_write    = 1'b0;
      bubble.jump         = 1'b0;
      bubble.jr           = 1'b0;
      bubble.alu_op       = 3'b000;
   end

`ifdef ID_EX_HAZARD_DETECT_EN
   logic                 uses_rt;
   logic [CNT_WIDTH-1:0] cnt_d, cnt_q;

   // Load in EX whose destination is read by the decode-stage instruction
   always_comb begin
      uses_rt = bus.reg_dst_i | bus.mem_write_i | bus.branch_eq_i | bus.branch_ne_i;
      hazard  = stage_q.valid & stage_q.mem_read & (stage_q.rt != 5'd0) &
                ((stage_q.rt == bus.rs_i) | ((stage_q.rt == bus.rt_i) & uses_rt));
   end

   // Count inserted hazard bubbles, saturating at all-ones
   always_comb begin
      cnt_d = cnt_q;
      if (!bus.flush_i && !bus.hold_i && hazard && (cnt_q != {CNT_WIDTH{1'b1}}))
         cnt_d = cnt_q + 1'b1;
   end

   // Bubble counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign bus.stall_o        = hazard & ~bus.flush_i & ~bus.hold_i;
   assign bus.bubble_count_o = cnt_q;
`else
   assign hazard             = 1'b0;
   assign bus.stall_o        = 1'b0;
   assign bus.bubble_count_o = '0;
`endif

   // Next-state selection: flush > hold > hazard > normal load
   always_comb begin
      stage_d = incoming;
      if (bus.flush_i)     stage_d = bubble;
      else if (bus.hold_i) stage_d = stage_q;
      else if (hazard)     stage_d = bubble;
   end

   // Pipeline register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) stage_q <= '0;
      else       stage_q <= stage_d;
   end

   assign bus.valid_o       = stage_q.valid;
   assign bus.reg_dst_o     = stage_q.reg_dst;
   assign bus.branch_eq_o   = stage_q.branch_eq;
   assign bus.branch_ne_o   = stage_q.branch_ne;
   assign bus.mem_read_o    = stage_q.mem_read;
   assign bus.mem_to_reg_o  = stage_q.mem_to_reg;
   assign bus.mem_write_o   = stage_q.mem_write;
   assign bus.alu_src_o     = stage_q.alu_src;
   assign bus.reg_write_o   = stage_q.reg_write;
   assign bus.jump_o        = stage_q.jump;
   assign bus.jr_o          = stage_q.jr;
   assign bus.alu_op_o      = stage_q.alu_op;
   assign bus.rs_o          = stage_q.rs;
   assign bus.rt_o          = stage_q.rt;
   assign bus.rd_o          = stage_q.rd;
   assign bus.read_data_1_o = stage_q.rd1;
   assign bus.read_data_2_o = stage_q.rd2;
   assign bus.imm_ext_o     = stage_q.imm;
   assign bus.pc_plus4_o    = stage_q.pc4;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage (counter width 2 to reach saturation).
module tb_id_ex_stage;
   localparam int DW = 32;
   localparam int CW = 2;
`ifdef ID_EX_HAZARD_DETECT_EN
   localparam bit HAZ = 1'b1;
`else
   localparam bit HAZ = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   exp_cnt = 0;

   id_ex_stage_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
   id_ex_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      bus.reg_dst_i = 0; bus.branch_eq_i = 0; bus.branch_ne_i = 0; bus.mem_read_i = 0;
      bus.mem_to_reg_i = 0; bus.mem_write_i = 0; bus.alu_src_i = 0; bus.reg_write_i = 0;
      bus.jump_i = 0; bus.jr_i = 0; bus.alu_op_i = 3'b000;
      bus.rs_i = 0; bus.rt_i = 0; bus.rd_i = 0;
      bus.read_data_1_i = 0; bus.read_data_2_i = 0; bus.imm_ext_i = 0; bus.pc_plus4_i = 0;
      bus.flush_i = 0; bus.hold_i = 0;
   endtask

   task automatic drive_lw(input logic [4:0] rs, input logic [4:0] rt);
      clr();
      bus.mem_read_i = 1; bus.mem_to_reg_i = 1; bus.alu_src_i = 1; bus.reg_write_i = 1;
      bus.rs_i = rs; bus.rt_i = rt; bus.imm_ext_i = 32'h4; bus.pc_plus4_i = 32'h100;
   endtask

   task automatic drive_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      clr();
      bus.reg_dst_i = 1; bus.reg_write_i = 1; bus.alu_op_i = 3'b010;
      bus.rs_i = rs; bus.rt_i = rt; bus.rd_i = rd;
      bus.read_data_1_i = 32'hAAAA_0001; bus.read_data_2_i = 32'h5555_0002; bus.pc_plus4_i = 32'h104;
   endtask

   task automatic drive_addi(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] imm);
      clr();
      bus.alu_src_i = 1; bus.reg_write_i = 1; bus.alu_op_i = 3'b100;
      bus.rs_i = rs; bus.rt_i = rt; bus.imm_ext_i = imm; bus.read_data_1_i = 32'h10;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      clr();
      tick();
      tests++; if (bus.valid_o !== 1'b0) begin $display("FAIL rst_valid: got %0h want 0", bus.valid_o); fails++; end
      tests++; if (bus.bubble_count_o !== 2'd0) begin $display("FAIL rst_cnt: got %0d want 0", bus.bubble_count_o); fails++; end
      reset = 0;
      drive_addi(5'd3, 5'd4, 32'hDEAD_BEEF);
      tick();
      tests++; if (bus.imm_ext_o !== 32'hDEAD_BEEF) begin $display("FAIL pre_rst_imm: got %0h want deadbeef", bus.imm_ext_o); fails++; end
      // asynchronous reset mid-cycle
      #2 reset = 1;
      #1;
      tests++; if (bus.valid_o !== 1'b0) begin $display("FAIL async_valid: got %0h want 0", bus.valid_o); fails++; end
      tests++; if (bus.reg_write_o !== 1'b0) begin $display("FAIL async_rw: got %0h want 0", bus.reg_write_o); fails++; end
      tests++; if (bus.imm_ext_o !== 32'h0) begin $display("FAIL async_imm: got %0h want 0", bus.imm_ext_o); fails++; end
      tests++; if (bus.read_data_1_o !== 32'h0) begin $display("FAIL async_rd1: got %0h want 0", bus.read_data_1_o); fails++; end
      #1 reset = 0;
      drive_addi(5'd3, 5'd4, 32'h5);
      tick();
      tests++; if (bus.valid_o !== 1'b1) begin $display("FAIL addi_valid: got %0h want 1", bus.valid_o); fails++; end
      tests++; if (bus.reg_write_o !== 1'b1) begin $display("FAIL addi_rw: got %0h want 1", bus.reg_write_o); fails++; end
      tests++; if (bus.alu_src_o !== 1'b1) begin $display("FAIL addi_src: got %0h want 1", bus.alu_src_o); fails++; end
      tests++; if (bus.alu_op_o !== 3'b100) begin $display("FAIL addi_op: got %0h want 4", bus.alu_op_o); fails++; end
      tests++; if (bus.imm_ext_o !== 32'h5) begin $display("FAIL addi_imm: got %0h want 5", bus.imm_ext_o); fails++; end
      tests++; if (bus.rt_o !== 5'd4) begin $display("FAIL addi_rt: got %0d want 4", bus.rt_o); fails++; end
   endtask

   task automatic test_load_use();
      drive_lw(5'd2, 5'd8);
      tick();
      tests++; if (bus.mem_read_o !== 1'b1) begin $display("FAIL lw_mr: got %0h want 1", bus.mem_read_o); fails++; end
      drive_add(5'd8, 5'd7, 5'd10);
      #1;
      tests++; if (bus.stall_o !== HAZ) begin $display("FAIL lu_stall: got %0h want %0h", bus.stall_o, HAZ); fails++; end
      tick();
      if (HAZ) exp_cnt++;
      tests++; if (bus.valid_o !== !HAZ) begin $display("FAIL lu_bub_valid: got %0h want %0h", bus.valid_o, !HAZ); fails++; end
      tests++; if (bus.reg_write_o !== !HAZ) begin $display("FAIL lu_bub_rw: got %0h want %0h", bus.reg_write_o, !HAZ); fails++; end
      tests++; if (bus.bubble_count_o !== exp_cnt[1:0]) begin $display("FAIL lu_cnt: got %0d want %0d", bus.bubble_count_o, exp_cnt); fails++; end
      tests++; if (bus.stall_o !== 1'b0) begin $display("FAIL lu_stall_clr: got %0h want 0", bus.stall_o); fails++; end
      tick();
      tests++; if (bus.valid_o !== 1'b1) begin $display("FAIL lu_add_valid: got %0h want 1", bus.valid_o); fails++; end
      tests++; if (bus.rd_o !== 5'd10) begin $display("FAIL lu_add_rd: got %0d want 10", bus.rd_o); fails++; end
      tests++; if (bus.reg_dst_o !== 1'b1) begin $display("FAIL lu_add_dst: got %0h want 1", bus.reg_dst_o); fails++; end
   endtask

   task automatic test_no_false_hazard();
      drive_lw(5'd1, 5'd0);
      tick();
      drive_add(5'd0, 5'd0, 5'd11);
      #1;
      tests++; if (bus.stall_o !== 1'b0) begin $display("FAIL nf_r0_stall: got %0h want 0", bus.stall_o); fails++; end
      tick();
      tests++; if (bus.valid_o !== 1'b1) begin $display("FAIL nf_r0_valid: got %0h want 1", bus.valid_o); fails++; end
      drive_lw(5'd1, 5'd9);
      tick();
      drive_addi(5'd3, 5'd9, 32'h7);
      #1;
      tests++; if (bus.stall_o !== 1'b0) begin $display("FAIL nf_rt_stall: got %0h want 0", bus.stall_o); fails++; end
      tick();
      tests++; if (bus.valid_o !== 1'b1) begin $display("FAIL nf_rt_valid: got %0h want 1", bus.valid_o); fails++; end
      tests++; if (bus.bubble_count_o !== exp_cnt[1:0]) begin $display("FAIL nf_cnt: got %0d want %0d", bus.bubble_count_o, exp_cnt); fails++; end
   endtask

   task automatic test_flush();
      drive_lw(5'd2, 5'd8);
      tick();
      drive_add(5'd8, 5'd7, 5'd12);
      bus.flush_i = 1;
      #1;
      tests++; if (bus.stall_o !== 1'b0) begin $display("FAIL fl_stall: got %0h want 0", bus.stall_o); fails++; end
      tick();
      tests++; if (bus.valid_o !== 1'b0) begin $display("FAIL fl_valid: got %0h want 0", bus.valid_o); fails++; end
      tests++; if (bus.reg_write_o !== 1'b0) begin $display("FAIL fl_rw: got %0h want 0", bus.reg_write_o); fails++; end
      tests++; if (bus.bubble_count_o !== exp_cnt[1:0]) begin $display("FAIL fl_cnt: got %0d want %0d", bus.bubble_count_o, exp_cnt); fails++; end
      // flush dominates hold
      drive_addi(5'd1, 5'd2, 32'h9);
      tick();
      bus.hold_i = 1; bus.flush_i = 1;
      tick();
      tests++; if (bus.valid_o !== 1'b0) begin $display("FAIL flh_valid: got %0h want 0", bus.valid_o); fails++; end
      tests++; if (bus.alu_op_o !== 3'b000) begin $display("FAIL flh_op: got %0h want 0", bus.alu_op_o); fails++; end
      clr();
   endtask

   task automatic test_hold();
      drive_addi(5'd1, 5'd2, 32'h11);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive_add(5'd5, 5'd6, 5'd7);
         bus.imm_ext_i = 32'h20 + i;
         bus.hold_i = 1;
         tick();
         tests++; if (bus.imm_ext_o !== 32'h11 || bus.rt_o !== 5'd2 || bus.reg_dst_o !== 1'b0)
            begin $display("FAIL hold_frz%0d: got imm %0h rt %0d want 11/2", i, bus.imm_ext_o, bus.rt_o); fails++; end
      end
      drive_addi(5'd1, 5'd3, 32'h33);
      tick();
      tests++; if (bus.imm_ext_o !== 32'h33 || bus.rt_o !== 5'd3) begin $display("FAIL hold_rel: got imm %0h rt %0d want 33/3", bus.imm_ext_o, bus.rt_o); fails++; end
      // load, hold two cycles, then dependent instruction
      drive_lw(5'd2, 5'd8);
      tick();
      for (int i = 0; i < 2; i++) begin
         drive_add(5'd8, 5'd1, 5'd13);
         bus.hold_i = 1;
         #1;
         tests++; if (bus.stall_o !== 1'b0) begin $display("FAIL hl_stall%0d: got %0h want 0", i, bus.stall_o); fails++; end
         tick();
      end
      drive_add(5'd8, 5'd1, 5'd13);
      #1;
      tests++; if (bus.stall_o !== HAZ) begin $display("FAIL hl_stall_rel: got %0h want %0h", bus.stall_o, HAZ); fails++; end
      tick();
      if (HAZ) exp_cnt++;
      tests++; if (bus.valid_o !== !HAZ) begin $display("FAIL hl_bub: got %0h want %0h", bus.valid_o, !HAZ); fails++; end
      tests++; if (bus.bubble_count_o !== exp_cnt[1:0]) begin $display("FAIL hl_cnt: got %0d want %0d", bus.bubble_count_o, exp_cnt); fails++; end
      tick();
      tests++; if (bus.valid_o !== 1'b1 || bus.rd_o !== 5'd13) begin $display("FAIL hl_add: got v %0h rd %0d want 1/13", bus.valid_o, bus.rd_o); fails++; end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 5; i++) begin
         drive_lw(5'd2, 5'd8);
         tick();
         drive_add(5'd4, 5'd8, 5'd14);
         #1;
         tests++; if (bus.stall_o !== HAZ) begin $display("FAIL sat_stall%0d: got %0h want %0h", i, bus.stall_o, HAZ); fails++; end
         tick();
         if (HAZ && exp_cnt < 3) exp_cnt++;
         tick();
         tests++; if (bus.bubble_count_o !== exp_cnt[1:0]) begin $display("FAIL sat_cnt%0d: got %0d want %0d", i, bus.bubble_count_o, exp_cnt); fails++; end
      end
      tests++; if (bus.bubble_count_o !== (HAZ ? 2'd3 : 2'd0)) begin $display("FAIL sat_final: got %0d want %0d", bus.bubble_count_o, HAZ ? 3 : 0); fails++; end
   endtask

   initial begin
      clr();
      test_reset();
      test_load_use();
      test_no_false_hazard();
      test_flush();
      test_hold();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
